// File: rtl/pixel_demux.sv
// Pixel demultiplexer: a small FIFO plus one output holding register that offers each
// buffered pixel to exactly one of four layer ports, in strict arrival order.
module pixel_demux #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [5:0]                   in_pixel,
    input  logic [1:0]                   in_select,
    input  logic [ADDR_W-1:0]            in_addr,
    output logic [3:0]                   out_valid,
    input  logic [3:0]                   out_ready,
    output logic [5:0]                   out_pixel,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [$clog2(DEPTH+2)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(DEPTH + 2);
    localparam int EW = 2 + ADDR_W + 6;

    logic [EW-1:0]     mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     occ_q, occ_d;
    logic              rdy_q, rdy_d;
    logic              ovld_q, ovld_d;
    logic [1:0]        osel_q, osel_d;
    logic [5:0]        opix_q, opix_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;

    logic              push, xfer, load;
    logic [EW-1:0]     head;

    assign push = in_valid & rdy_q;
    assign xfer = ovld_q & out_ready[osel_q];
    // Refill the holding register whenever it is free this edge and the FIFO has data.
    assign load = (~ovld_q | xfer) & (occ_q != '0);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        rdy_d    = rdy_q;
        ovld_d   = ovld_q;
        osel_d   = osel_q;
        opix_d   = opix_q;
        oaddr_d  = oaddr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            ovld_d   = 1'b0;
            rdy_d    = 1'b1;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (load) rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !load)
                occ_d = occ_q + OW'(1);
            else if (load && !push)
                occ_d = occ_q - OW'(1);
            if (load) begin
                ovld_d  = 1'b1;
                osel_d  = head[EW-1 -: 2];
                oaddr_d = head[6 +: ADDR_W];
                opix_d  = head[5:0];
            end else if (xfer) begin
                ovld_d = 1'b0;
            end
            // Registered ready reflects next-cycle FIFO room only; no same-cycle bypass.
            rdy_d = (occ_d < OW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            rdy_q    <= 1'b0;
            ovld_q   <= 1'b0;
            osel_q   <= '0;
            opix_q   <= '0;
            oaddr_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            rdy_q    <= rdy_d;
            ovld_q   <= ovld_d;
            osel_q   <= osel_d;
            opix_q   <= opix_d;
            oaddr_q  <= oaddr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push)
            mem_q[wr_ptr_q] <= {in_select, in_addr, in_pixel};
    end

    assign in_ready  = rdy_q;
    assign out_valid = ovld_q ? (4'b0001 << osel_q) : 4'b0000;
    assign out_pixel = opix_q;
    assign out_addr  = oaddr_q;
    assign count     = CW'(occ_q) + CW'(ovld_q);

endmodule

// File: doc/pixel_demux.md
PIXEL_DEMUX -- requirements
Module: pixel_demux

Interface
REQ-001 Parameter: DEPTH, default 4, number of FIFO entries; power of two, minimum 2.
REQ-002 Parameter: ADDR_W, default 8, width of the pixel address carried with each pixel.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 flush  input  1  synchronous discard of all buffered pixels (frame/vsync boundary).
REQ-006 in_valid  input  1  upstream pixel write present.
REQ-007 in_ready  output  1  block accepts the upstream write this cycle.
REQ-008 in_pixel  input  6  pixel value (2b R, 2b G, 2b B).
REQ-009 in_select  input  2  destination layer port, 0..3.
REQ-010 in_addr  input  ADDR_W  destination pixel address.
REQ-011 out_valid  output  4  one-hot; bit s set = held pixel is offered to layer port s.
REQ-012 out_ready  input  4  per-port acceptance from the four layer buffers.
REQ-013 out_pixel  output  6  shared pixel bus to all four ports.
REQ-014 out_addr  output  ADDR_W  shared address bus to all four ports.
REQ-015 count  output  clog2(DEPTH+2)  entries held, FIFO plus output register.

Function
REQ-016 Input transfer SHALL occur when in_valid & in_ready; the block SHALL store {in_select, in_addr, in_pixel} as one entry.
REQ-017 Storage SHALL be a DEPTH-entry FIFO feeding one output holding register; total capacity is DEPTH+1.
REQ-018 in_ready SHALL be registered and SHALL equal (FIFO occupancy < DEPTH); there is no same-cycle full bypass, so a pop does not raise in_ready in that cycle.
REQ-019 While the output register holds an entry with select s, out_valid SHALL be exactly one-hot at bit s and out_pixel/out_addr SHALL show that entry; otherwise out_valid SHALL be 4'b0000.
REQ-020 Output transfer SHALL occur when out_valid[s] & out_ready[s]; out_ready bits for non-selected ports SHALL be ignored.
REQ-021 The output register SHALL load the FIFO head at the clock edge where it is empty or its transfer completes; back-to-back pixels SHALL stream at one per cycle.
REQ-022 Latency: a write accepted at edge N into an empty block SHALL appear on out_valid after edge N+1; the write does not bypass the FIFO.
REQ-023 Ordering SHALL be strictly first-in first-out across all ports; a stalled port SHALL block all later entries (head-of-line blocking), with no reordering.
REQ-024 Held outputs SHALL remain stable while out_valid is set and the selected out_ready is low.
REQ-025 FIFO read and write pointers SHALL wrap modulo DEPTH; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-026 count SHALL update at each edge: +1 on push only, -1 on output transfer only, unchanged on both or neither.
REQ-027 flush SHALL, at the next edge, clear pointers, occupancy and output register (count=0, out_valid=0, in_ready=1).
REQ-028 A write presented in the same cycle as flush SHALL be discarded; flush SHALL take priority over push and pop.

Reset
REQ-029 While rst is high at an edge, state SHALL become: count=0, out_valid=4'b0000, in_ready=0.
REQ-030 in_ready SHALL return to 1 at the first edge with rst low; rst SHALL override flush and all transfers.
REQ-031 out_pixel and out_addr SHALL reset to 0.
REQ-032 Reset asserted mid-stream SHALL discard all buffered entries; no stale pixel SHALL reappear after reset.

Verification
REQ-033 Single write (sel=2, addr=0x10, pixel=0x2A) with out_ready=4'hF -> out_valid=4'b0100 one cycle after accept; out_addr=0x10, out_pixel=0x2A; count returns to 0.
REQ-034 Stream 8 writes with sel cycling 0,1,2,3 and out_ready=4'hF -> one output per cycle, in order, with out_valid cycling 0001, 0010, 0100, 1000.
REQ-035 out_ready=0, write DEPTH+1 entries -> in_ready low after DEPTH FIFO entries, count=5; then out_ready=4'hF -> all five drain in order.
REQ-036 Head sel=1 with out_ready=4'b1101 -> out_valid=0010 held stable; later entries not emitted until out_ready[1] rises.
REQ-037 flush with count=3 and a simultaneous write -> next cycle count=0, out_valid=0; the flushed-cycle write never appears.
REQ-038 rst pulsed mid-stream -> count=0, out_valid=0, in_ready=0 during reset, in_ready=1 after; no pre-reset pixel is output.
